math_round_ctrl: RTL and testbench

Round controller for the math-challenge game: generates operand pairs, loads the countdown timer, accepts the player's answer, and judges it against the timer. It sits on the opposite side of the countdown timer's interface: it drives the timer's active-low load input and consumes its 4-bit count. It also keeps score over a fixed number of rounds. It is a single-clock block sharing `clk` and `reset` with the timer.

---
 rtl/math_round_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_math_round_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/math_round_ctrl.sv
// Round controller for the math-challenge game.
// Picks operand pairs from a free-running LFSR, pulses the countdown timer's
// load input, judges the player's answer (or a timeout) and keeps the score
// over a fixed number of rounds. All outputs are registered.
module math_round_ctrl #(
    parameter int         ROUNDS        = 8,
    parameter int         RESULT_CYCLES = 4,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] timer,
    input  logic       answer_valid,
    input  logic [4:0] answer,
    output logic       timer_load_n,
    output logic       answer_ack,
    output logic [3:0] operand_a,
    output logic [3:0] operand_b,
    output logic       correct,
    output logic       wrong,
    output logic       timeout,
    output logic [3:0] score,
    output logic [3:0] round,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ASK    = 3'd2,
        RESULT = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0] RESULT_LOAD = 8'(RESULT_CYCLES - 1);
    localparam logic [3:0] ROUNDS_L    = 4'(ROUNDS);

    // Fibonacci LFSR step: taps 8,6,5,4, shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] lfsr_r;
    logic [7:0] cnt_r;
    logic       timer_load_n_r;
    logic       answer_ack_r;
    logic [3:0] operand_a_r;
    logic [3:0] operand_b_r;
    logic       correct_r;
    logic       wrong_r;
    logic       timeout_r;
    logic [3:0] score_r;
    logic [3:0] round_r;
    logic       game_over_r;

    logic       ask_answer_s;
    logic       ask_timeout_s;
    logic       answer_ok_s;
    logic [4:0] expected_s;
    logic       new_game_s;

    // Next-state decode; an answer in the same cycle as timer==0 wins.
    always_comb begin
        next_state_s  = state_r;
        ask_answer_s  = 1'b0;
        ask_timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = LOAD;
                else       next_state_s = IDLE;
            end
            LOAD: next_state_s = ASK;
            ASK: begin
                if (answer_valid) begin
                    next_state_s = RESULT;
                    ask_answer_s = 1'b1;
                end else if (timer == 4'd0) begin
                    next_state_s  = RESULT;
                    ask_timeout_s = 1'b1;
                end else begin
                    next_state_s = ASK;
                end
            end
            RESULT: begin
                if (cnt_r == 8'd0) begin
                    if (round_r == ROUNDS_L) next_state_s = DONE;
                    else                     next_state_s = LOAD;
                end else begin
                    next_state_s = RESULT;
                end
            end
            DONE: begin
                if (start) next_state_s = LOAD;
                else       next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Answer judgement: 5-bit sum of the latched operands cannot overflow.
    always_comb begin
        expected_s  = {1'b0, operand_a_r} + {1'b0, operand_b_r};
        answer_ok_s = (answer == expected_s);
        new_game_s  = start && ((state_r == IDLE) || (state_r == DONE));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Operand LFSR runs every cycle; operands are captured during LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_r      <= LFSR_SEED;
            operand_a_r <= 4'd0;
            operand_b_r <= 4'd0;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
            if (state_r == LOAD) begin
                operand_a_r <= lfsr_r[3:0];
                operand_b_r <= lfsr_r[7:4];
            end
        end
    end

    // Strobes registered from the decode so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_load_n_r <= 1'b1;
            answer_ack_r   <= 1'b0;
            game_over_r    <= 1'b0;
        end else begin
            timer_load_n_r <= (next_state_s != LOAD);
            answer_ack_r   <= ask_answer_s;
            game_over_r    <= (next_state_s == DONE);
        end
    end

    // Verdict flags: set on entry to RESULT, cleared on entry to LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            correct_r <= 1'b0;
            wrong_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else if (next_state_s == LOAD) begin
            correct_r <= 1'b0;
            wrong_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else if (ask_answer_s) begin
            correct_r <= answer_ok_s;
            wrong_r   <= !answer_ok_s;
            timeout_r <= 1'b0;
        end else if (ask_timeout_s) begin
            correct_r <= 1'b0;
            wrong_r   <= 1'b0;
            timeout_r <= 1'b1;
        end
    end

    // Score/round bookkeeping and the RESULT hold counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_r <= 4'd0;
            round_r <= 4'd0;
            cnt_r   <= 8'd0;
        end else begin
            if (new_game_s) begin
                score_r <= 4'd0;
                round_r <= 4'd0;
            end else if (ask_answer_s || ask_timeout_s) begin
                round_r <= round_r + 4'd1;
                if (ask_answer_s && answer_ok_s) score_r <= score_r + 4'd1;
            end
            if (ask_answer_s || ask_timeout_s) begin
                cnt_r <= RESULT_LOAD;
            end else if ((state_r == RESULT) && (cnt_r != 8'd0)) begin
                cnt_r <= cnt_r - 8'd1;
            end
        end
    end

    assign timer_load_n = timer_load_n_r;
    assign answer_ack   = answer_ack_r;
    assign operand_a    = operand_a_r;
    assign operand_b    = operand_b_r;
    assign correct      = correct_r;
    assign wrong        = wrong_r;
    assign timeout      = timeout_r;
    assign score        = score_r;
    assign round        = round_r;
    assign game_over    = game_over_r;

endmodule

// File: tb/tb_math_round_ctrl.sv
// Directed bench for math_round_ctrl: drives the timer value directly and
// keeps its own copy of the operand LFSR to predict the questions.
module tb_math_round_ctrl;

    localparam int ROUNDS        = 8;
    localparam int RESULT_CYCLES = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] timer;
    logic       answer_valid;
    logic [4:0] answer;
    logic       timer_load_n;
    logic       answer_ack;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic       correct;
    logic       wrong;
    logic       timeout;
    logic [3:0] score;
    logic [3:0] round;
    logic       game_over;

    int n_cmp;
    int n_err;
    int exp_score;
    int exp_round;
    logic [7:0] m_lfsr;

    math_round_ctrl #(
        .ROUNDS(ROUNDS),
        .RESULT_CYCLES(RESULT_CYCLES),
        .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .timer(timer),
        .answer_valid(answer_valid),
        .answer(answer),
        .timer_load_n(timer_load_n),
        .answer_ack(answer_ack),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .correct(correct),
        .wrong(wrong),
        .timeout(timeout),
        .score(score),
        .round(round),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, advancing every cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_load_n"}, {7'd0, timer_load_n}, 8'd1);
        chk({tag, "_ack"},    {7'd0, answer_ack},   8'd0);
        chk({tag, "_ops"},    {operand_b, operand_a}, 8'd0);
        chk({tag, "_flags"},  {5'd0, correct, wrong, timeout}, 8'd0);
        chk({tag, "_score"},  {4'd0, score}, 8'd0);
        chk({tag, "_round"},  {4'd0, round}, 8'd0);
        chk({tag, "_gover"},  {7'd0, game_over}, 8'd0);
    endtask

    // One round, entered in the LOAD cycle.
    // kind: 0 correct, 1 wrong (sum+1), 2 answer 31, 3 timeout, 4 correct with timer==0.
    task automatic play_round(input int kind);
        logic [3:0] ea;
        logic [3:0] eb;
        logic [4:0] sum;
        logic       e_cor;
        logic       e_wr;
        logic       e_to;
        int         rc;
        int         guard;
        chk("load_n_low", {7'd0, timer_load_n}, 8'd0);
        chk("flags_clr_in_load", {5'd0, correct, wrong, timeout}, 8'd0);
        ea  = m_lfsr[3:0];
        eb  = m_lfsr[7:4];
        sum = {1'b0, ea} + {1'b0, eb};
        step();  // first ASK cycle
        chk("load_n_one_cycle", {7'd0, timer_load_n}, 8'd1);
        chk("operand_a", {4'd0, operand_a}, {4'd0, ea});
        chk("operand_b", {4'd0, operand_b}, {4'd0, eb});
        step();  // second ASK cycle
        case (kind)
            0: begin answer_valid = 1'b1; answer = sum; end
            1: begin answer_valid = 1'b1; answer = sum + 5'd1; end
            2: begin answer_valid = 1'b1; answer = 5'd31; end
            3: begin timer = 4'd0; end
            4: begin timer = 4'd0; answer_valid = 1'b1; answer = sum; end
            default: begin answer_valid = 1'b0; end
        endcase
        step();  // first RESULT cycle
        answer_valid = 1'b0;
        timer = 4'd10;
        e_cor = (kind == 0) || (kind == 4);
        e_wr  = (kind == 1) || (kind == 2);
        e_to  = (kind == 3);
        if (e_cor) exp_score++;
        exp_round++;
        chk("answer_ack", {7'd0, answer_ack}, {7'd0, !e_to});
        chk("verdict", {5'd0, correct, wrong, timeout}, {5'd0, e_cor, e_wr, e_to});
        chk("score", {4'd0, score}, 8'(exp_score));
        chk("round", {4'd0, round}, 8'(exp_round));
        // answer_valid during RESULT must be ignored
        answer_valid = 1'b1;
        answer = sum;
        step();
        answer_valid = 1'b0;
        chk("ack_low_in_result", {7'd0, answer_ack}, 8'd0);
        chk("score_stable", {4'd0, score}, 8'(exp_score));
        rc = 1;
        guard = 0;
        while (timer_load_n === 1'b1 && game_over !== 1'b1 && guard < 20) begin
            chk("verdict_held", {5'd0, correct, wrong, timeout}, {5'd0, e_cor, e_wr, e_to});
            rc++;
            guard++;
            step();
        end
        chk("result_len", 8'(rc), 8'(RESULT_CYCLES));
        if (exp_round == ROUNDS) begin
            chk("game_over", {7'd0, game_over}, 8'd1);
        end else begin
            chk("next_load", {7'd0, timer_load_n}, 8'd0);
        end
    endtask

    task automatic begin_game();
        start = 1'b1;
        step();  // LOAD cycle
        start = 1'b0;
        exp_score = 0;
        exp_round = 0;
        chk("new_score", {4'd0, score}, 8'd0);
        chk("new_round", {4'd0, round}, 8'd0);
        chk("new_gover", {7'd0, game_over}, 8'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_score = 0;
        exp_round = 0;
        reset = 1'b0;
        start = 1'b0;
        timer = 4'd10;
        answer_valid = 1'b0;
        answer = 5'd0;
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk_reset_vals("idle20");

        // Game 1: mixed verdicts, score 4 of 8.
        begin_game();
        play_round(0);
        play_round(1);
        play_round(2);
        play_round(3);
        play_round(4);
        play_round(0);
        play_round(3);
        play_round(0);
        chk("g1_score", {4'd0, score}, 8'd4);
        chk("g1_round", {4'd0, round}, 8'd8);
        step();
        step();
        chk("done_hold_gover", {7'd0, game_over}, 8'd1);
        chk("done_hold_score", {4'd0, score}, 8'd4);
        chk("done_load_n", {7'd0, timer_load_n}, 8'd1);

        // Game 2: start from DONE, 5 correct and 3 timeouts.
        begin_game();
        play_round(0);
        play_round(0);
        play_round(3);
        play_round(0);
        play_round(3);
        play_round(0);
        play_round(3);
        play_round(0);
        chk("g2_gover", {7'd0, game_over}, 8'd1);
        chk("g2_score", {4'd0, score}, 8'd5);
        chk("g2_round", {4'd0, round}, 8'd8);

        // Game 3: reset during RESULT of round 3.
        begin_game();
        play_round(0);
        play_round(1);
        step();  // ASK 1
        step();  // ASK 2
        answer_valid = 1'b1;
        answer = 5'd0;
        step();  // RESULT 1
        answer_valid = 1'b0;
        chk("g3_round3", {4'd0, round}, 8'd3);
        step();  // RESULT 2
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("midreset");
        step();
        reset = 1'b1;
        step();
        answer_valid = 1'b1;
        answer = 5'd5;
        step();
        answer_valid = 1'b0;
        chk("idle_no_ack", {7'd0, answer_ack}, 8'd0);
        chk("idle_score", {4'd0, score}, 8'd0);
        chk("idle_load_n", {7'd0, timer_load_n}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
